// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : icache_assoc
// Brief    : Blocking read-only instruction cache, 1- or 2-way set associative,
//            per-set LRU, registered line refill and whole-cache flush.
// Revision : 1.0
// ============================================================================
module icache_assoc #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 16,
    parameter int SETS       = 64,
    parameter int WAYS       = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         cpu_addr_valid,
    input  logic [ADDR_W-1:0]            cpu_addr,
    output logic                         cpu_data_ready,
    output logic [DATA_W-1:0]            cpu_data_o,
    output logic                         mem_addr_valid,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_data_ready,
    input  logic [LINE_WORDS*DATA_W-1:0] mem_data_i
);

    localparam int LINE_W = LINE_WORDS * DATA_W;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int WORD_W = OFF_W - BYTE_W;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_REFILL = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [LINE_W-1:0]     r_line  [WAYS][SETS];
    logic [TAG_W-1:0]      r_tag   [WAYS][SETS];
    logic [SETS-1:0]       r_valid [WAYS];
    logic [SETS-1:0]       r_lru;
    logic                  r_flush_pend;
    logic                  r_mem_addr_valid;
    logic [ADDR_W-1:0]     r_mem_addr;

    logic [TAG_W-1:0]      w_tag;
    logic [IDX_W-1:0]      w_idx;
    logic [WORD_W-1:0]     w_word;
    logic [1:0]            w_way_hit;
    logic                  w_hit_way;
    logic                  w_lookup_hit;
    logic [LINE_W-1:0]     w_hit_line;
    logic [DATA_W-1:0]     w_words [LINE_WORDS];
    logic                  w_victim;
    logic                  w_fill;
    logic                  w_flush_now;
    logic [IDX_W-1:0]      w_fill_idx;
    logic [TAG_W-1:0]      w_fill_tag;
    logic                  w_unused_lsbs;

    assign w_tag         = cpu_addr[ADDR_W-1 -: TAG_W];
    assign w_idx         = cpu_addr[OFF_W +: IDX_W];
    assign w_word        = cpu_addr[BYTE_W +: WORD_W];
    assign w_unused_lsbs = ^cpu_addr[BYTE_W-1:0];

    // The refill address register doubles as the latched tag/index of the miss.
    assign w_fill_idx  = r_mem_addr[OFF_W +: IDX_W];
    assign w_fill_tag  = r_mem_addr[ADDR_W-1 -: TAG_W];
    assign w_fill      = (r_state == S_REFILL) && mem_data_ready;
    assign w_flush_now = r_flush_pend || flush;

    for (genvar g = 0; g < WAYS; g++) begin : g_way_hit
        assign w_way_hit[g] = r_valid[g][w_idx] && (r_tag[g][w_idx] == w_tag);
    end

    if (WAYS == 2) begin : g_victim2
        assign w_victim = !r_valid[0][w_fill_idx] ? 1'b0 :
                          !r_valid[1][w_fill_idx] ? 1'b1 : r_lru[w_fill_idx];
        assign w_hit_way = w_way_hit[1] && !w_way_hit[0];
    end else begin : g_victim1
        assign w_way_hit[1] = 1'b0;
        assign w_victim     = 1'b0;
        assign w_hit_way    = 1'b0;
    end

    assign w_hit_line = r_line[w_hit_way][w_idx];

    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_words
        assign w_words[k] = w_hit_line[k*DATA_W +: DATA_W];
    end

    assign mem_addr_valid = r_mem_addr_valid;
    assign mem_addr       = r_mem_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_lookup_hit   = 1'b0;
        cpu_data_ready = 1'b0;
        cpu_data_o     = '0;
        case (r_state)
            S_IDLE: begin
                w_lookup_hit = cpu_addr_valid && !flush && (|w_way_hit);
                if (cpu_addr_valid && !flush && !(|w_way_hit)) begin
                    w_next_state = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_data_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        cpu_data_ready = w_lookup_hit;
        if (w_lookup_hit) begin
            cpu_data_o = w_words[w_word];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid          <= '{default: '0};
            r_lru            <= '0;
            r_flush_pend     <= 1'b0;
            r_mem_addr_valid <= 1'b0;
            r_mem_addr       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_valid <= '{default: '0};
                    end else if (cpu_addr_valid) begin
                        if (|w_way_hit) begin
                            if (WAYS == 2) begin
                                r_lru[w_idx] <= ~w_hit_way;
                            end
                        end else begin
                            r_mem_addr       <= {w_tag, w_idx, {OFF_W{1'b0}}};
                            r_mem_addr_valid <= 1'b1;
                        end
                    end
                end
                S_REFILL: begin
                    if (mem_data_ready) begin
                        r_mem_addr_valid <= 1'b0;
                        r_flush_pend     <= 1'b0;
                        // A flush seen during the refill leaves the new line invalid too.
                        if (w_flush_now) begin
                            r_valid <= '{default: '0};
                        end else begin
                            r_valid[w_victim][w_fill_idx] <= 1'b1;
                        end
                        if (WAYS == 2) begin
                            r_lru[w_fill_idx] <= ~w_victim;
                        end
                    end else if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_line[w_victim][w_fill_idx] <= mem_data_i;
            r_tag[w_victim][w_fill_idx]  <= w_fill_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_assoc
// Brief    : Self-checking bench for icache_assoc (2-way and 1-way instances).
// Revision : 1.0
// ============================================================================
module tb_icache_assoc;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         cav = 1'b0;
    logic         mdr = 1'b0;
    logic         sel1 = 1'b0;
    logic [31:0]  cpu_addr = '0;
    logic [511:0] mem_data_i = '0;

    logic         rdy2, rdy1, mav2, mav1;
    logic [31:0]  dout2, dout1, maddr2, maddr1;
    logic         rdy, mav;
    logic [31:0]  dout, maddr_w;

    int checks = 0;
    int failures = 0;

    logic [31:0] mq[$];

    always #5 clk = ~clk;

    assign rdy     = sel1 ? rdy1 : rdy2;
    assign mav     = sel1 ? mav1 : mav2;
    assign dout    = sel1 ? dout1 : dout2;
    assign maddr_w = sel1 ? maddr1 : maddr2;

    icache_assoc #(.WAYS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .cpu_addr_valid(cav && !sel1), .cpu_addr(cpu_addr),
        .cpu_data_ready(rdy2), .cpu_data_o(dout2),
        .mem_addr_valid(mav2), .mem_addr(maddr2),
        .mem_data_ready(mdr && !sel1), .mem_data_i(mem_data_i)
    );

    icache_assoc #(.WAYS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .cpu_addr_valid(cav && sel1), .cpu_addr(cpu_addr),
        .cpu_data_ready(rdy1), .cpu_data_o(dout1),
        .mem_addr_valid(mav1), .mem_addr(maddr1),
        .mem_data_ready(mdr && sel1), .mem_data_i(mem_data_i)
    );

    // Backing memory contents: word k of the line holding address a.
    function automatic logic [31:0] lw(input logic [31:0] a, input int k);
        return ((a & 32'hFFFF_FFC0) ^ 32'hA000_1040) + k;
    endfunction

    function automatic logic [511:0] line_of(input logic [31:0] a);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = lw(a, k);
        return l;
    endfunction

    // Reference: global recency list of resident lines, at most two per set.
    function automatic bit m_has(input logic [31:0] ln);
        for (int i = 0; i < mq.size(); i++) if (mq[i] == ln) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_use(input logic [31:0] ln);
        int cnt = 0;
        int first = -1;
        int hit = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i] == ln) hit = i;
            if (mq[i][11:6] == ln[11:6]) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        if (hit >= 0) mq.delete(hit);
        else if (cnt == 2) mq.delete(first);
        mq.push_back(ln);
    endfunction

    task automatic pulse_flush;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    // Presents one fetch and services refills until it hits; reports what it saw.
    task automatic fetch(input logic [31:0] a, input int lat, input bit fl,
                         output int misses, output logic [31:0] maddr, output bit ok,
                         output logic [31:0] data, output bit to);
        bit fl_left;
        misses = 0; maddr = '0; ok = 1'b1; data = '0; to = 1'b0; fl_left = fl;
        cav = 1'b1; cpu_addr = a;
        for (int it = 0; it < 4; it++) begin
            @(negedge clk);
            if (rdy) begin
                data = dout;
                @(posedge clk); #1;
                cav = 1'b0;
                return;
            end
            misses++;
            @(posedge clk); #1;
            if (mav !== 1'b1) ok = 1'b0;
            maddr = maddr_w;
            for (int c = 0; c < lat; c++) begin
                if (fl_left && c == 0) begin flush = 1'b1; fl_left = 1'b0; end
                @(posedge clk); #1;
                flush = 1'b0;
                if (mav !== 1'b1 || maddr_w !== maddr || rdy !== 1'b0) ok = 1'b0;
            end
            if (fl_left) begin flush = 1'b1; fl_left = 1'b0; end
            mdr = 1'b1; mem_data_i = line_of(maddr);
            @(posedge clk); #1;
            mdr = 1'b0; flush = 1'b0;
            if (mav !== 1'b0) ok = 1'b0;
        end
        to = 1'b1; cav = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy2 !== 1'b0 || dout2 !== 32'h0 || mav2 !== 1'b0 || maddr2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_w2 rdy=%b dout=%h mav=%b maddr=%h exp 0/0/0/0", rdy2, dout2, mav2, maddr2);
        end
        checks++;
        if (rdy1 !== 1'b0 || dout1 !== 32'h0 || mav1 !== 1'b0 || maddr1 !== 32'h0) begin
            failures++;
            $display("FAIL reset_w1 rdy=%b dout=%h mav=%b maddr=%h exp 0/0/0/0", rdy1, dout1, mav1, maddr1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_miss;
        int m; logic [31:0] ma, d; bit ok, to;
        sel1 = 1'b0;
        cav = 1'b1; cpu_addr = 32'h0000_1044;
        @(negedge clk);
        checks++;
        if (rdy !== 1'b0) begin failures++; $display("FAIL miss_ready got=%b exp=0", rdy); end
        @(posedge clk); #1;
        checks++;
        if (mav !== 1'b1 || maddr_w !== 32'h0000_1040) begin
            failures++; $display("FAIL miss_req mav=%b addr=%h exp 1/00001040", mav, maddr_w);
        end
        @(posedge clk); #1;
        mdr = 1'b1; mem_data_i = line_of(32'h0000_1040);
        @(negedge clk);
        checks++;
        if (mav !== 1'b1 || rdy !== 1'b0) begin
            failures++; $display("FAIL refill_hold mav=%b rdy=%b exp 1/0", mav, rdy);
        end
        @(posedge clk); #1;
        mdr = 1'b0;
        checks++;
        if (mav !== 1'b0) begin failures++; $display("FAIL fill_drop mav=%b exp=0", mav); end
        @(negedge clk);
        checks++;
        if (rdy !== 1'b1 || dout !== 32'hA000_0001) begin
            failures++; $display("FAIL fill_hit rdy=%b data=%h exp 1/a0000001", rdy, dout);
        end
        @(posedge clk); #1;
        cav = 1'b0;
        fetch(32'h0000_1040, 0, 1'b0, m, ma, ok, d, to);
        checks++;
        if (m !== 0 || d !== 32'hA000_0000 || to) begin
            failures++; $display("FAIL hit_1040 misses=%0d data=%h exp 0/a0000000", m, d);
        end
        fetch(32'h0000_107C, 0, 1'b0, m, ma, ok, d, to);
        checks++;
        if (m !== 0 || d !== 32'hA000_000F || to) begin
            failures++; $display("FAIL hit_107c misses=%0d data=%h exp 0/a000000f", m, d);
        end
    endtask

    task automatic test_lru;
        logic [31:0] addrs [7] = '{32'h1000, 32'h2000, 32'h1000, 32'h3000, 32'h1000, 32'h3000, 32'h2000};
        int          expm  [7] = '{1, 1, 0, 1, 0, 0, 1};
        int m; logic [31:0] ma, d; bit ok, to;
        sel1 = 1'b0;
        pulse_flush;
        for (int i = 0; i < 7; i++) begin
            fetch(addrs[i], 1, 1'b0, m, ma, ok, d, to);
            checks++;
            if (m !== expm[i] || d !== lw(addrs[i], 0) || to || !ok || (m > 0 && ma !== addrs[i])) begin
                failures++;
                $display("FAIL lru step=%0d addr=%h misses=%0d exp=%0d data=%h exp=%h maddr=%h ok=%b to=%b",
                         i, addrs[i], m, expm[i], d, lw(addrs[i], 0), ma, ok, to);
            end
        end
    endtask

    task automatic test_ways1;
        logic [31:0] addrs [3] = '{32'h1000, 32'h2000, 32'h1000};
        int m; logic [31:0] ma, d; bit ok, to;
        sel1 = 1'b1;
        pulse_flush;
        for (int i = 0; i < 3; i++) begin
            fetch(addrs[i], 0, 1'b0, m, ma, ok, d, to);
            checks++;
            if (m !== 1 || ma !== addrs[i] || d !== lw(addrs[i], 0) || !ok || to) begin
                failures++;
                $display("FAIL ways1 step=%0d misses=%0d exp=1 maddr=%h exp=%h data=%h ok=%b",
                         i, m, ma, addrs[i], d, ok);
            end
        end
        sel1 = 1'b0;
    endtask

    task automatic test_flush_idle;
        logic [31:0] addrs [2] = '{32'h1000, 32'h2044};
        int m; logic [31:0] ma, d; bit ok, to;
        sel1 = 1'b0;
        pulse_flush;
        for (int i = 0; i < 2; i++) fetch(addrs[i], 0, 1'b0, m, ma, ok, d, to);
        fetch(32'h1000, 0, 1'b0, m, ma, ok, d, to);
        checks++;
        if (m !== 0) begin failures++; $display("FAIL pre_flush_hit misses=%0d exp=0", m); end
        pulse_flush;
        for (int i = 0; i < 2; i++) begin
            fetch(addrs[i], 0, 1'b0, m, ma, ok, d, to);
            checks++;
            if (m !== 1 || d !== lw(addrs[i], addrs[i][5:2])) begin
                failures++; $display("FAIL post_flush addr=%h misses=%0d exp=1 data=%h", addrs[i], m, d);
            end
        end
    endtask

    task automatic test_flush_refill;
        int m; logic [31:0] ma, d; bit ok, to;
        sel1 = 1'b0;
        for (int lat = 0; lat < 3; lat += 2) begin
            fetch(32'h4000 + lat * 32'h400, lat, 1'b1, m, ma, ok, d, to);
            checks++;
            if (m !== 2 || !ok || to || d !== lw(32'h4000 + lat * 32'h400, 0)) begin
                failures++;
                $display("FAIL flush_refill lat=%0d misses=%0d exp=2 ok=%b to=%b data=%h", lat, m, ok, to, d);
            end
        end
    endtask

    task automatic test_reset_refill;
        int m; logic [31:0] ma, d; bit ok, to;
        sel1 = 1'b0;
        cav = 1'b1; cpu_addr = 32'h5000;
        @(posedge clk); #1;
        checks++;
        if (mav !== 1'b1) begin failures++; $display("FAIL rst_pre mav=%b exp=1", mav); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mav !== 1'b0) begin failures++; $display("FAIL rst_async mav=%b exp=0", mav); end
        @(posedge clk); #1;
        rst_n = 1'b1; cav = 1'b0;
        mdr = 1'b1; mem_data_i = line_of(32'h5000);
        @(posedge clk); #1;
        mdr = 1'b0;
        checks++;
        if (mav !== 1'b0) begin failures++; $display("FAIL rst_late_ready mav=%b exp=0", mav); end
        fetch(32'h5000, 0, 1'b0, m, ma, ok, d, to);
        checks++;
        if (m !== 1 || ma !== 32'h5000) begin
            failures++; $display("FAIL rst_remiss misses=%0d exp=1 maddr=%h", m, ma);
        end
    endtask

    task automatic test_random;
        int m, lat, expm; logic [31:0] a, ma, d, ln; bit ok, to, fl, hit;
        sel1 = 1'b0;
        pulse_flush;
        mq.delete();
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(9) == 0) begin
                pulse_flush;
                mq.delete();
            end
            a = '0;
            a[31:12] = 20'($urandom_range(1, 4));
            a[7:6]   = 2'($urandom_range(3));
            a[5:2]   = 4'($urandom);
            ln  = a & 32'hFFFF_FFC0;
            lat = $urandom_range(0, 3);
            fl  = ($urandom_range(7) == 0);
            hit = m_has(ln);
            expm = hit ? 0 : (fl ? 2 : 1);
            fetch(a, lat, fl, m, ma, ok, d, to);
            checks++;
            if (m !== expm || d !== lw(a, a[5:2]) || to || !ok || (!hit && ma !== ln)) begin
                failures++;
                $display("FAIL random i=%0d addr=%h misses=%0d exp=%0d data=%h exp=%h maddr=%h ok=%b to=%b",
                         i, a, m, expm, d, lw(a, a[5:2]), ma, ok, to);
            end
            if (!hit && fl) mq.delete();
            m_use(ln);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic_miss;
        test_lru;
        test_ways1;
        test_flush_idle;
        test_flush_refill;
        test_reset_refill;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_assoc.md
# icache_assoc

Parametrised, blocking, read-only instruction cache between the CPU fetch port and the line-wide memory port. It generalises the direct-mapped cache to configurable line size, set count and 1- or 2-way associativity with per-set LRU replacement. It adds a registered refill state machine, line-aligned memory requests, reset-cleared valid bits and a whole-cache flush.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, CPU word width
- LINE_WORDS, 16, words per line (power of 2, ≥2)
- SETS, 64, sets (power of 2, ≥2)
- WAYS, 2, associativity; only 1 or 2 legal
- Derived: OFF_W = log2(LINE_WORDS·DATA_W/8), IDX_W = log2(SETS), TAG_W = ADDR_W − IDX_W − OFF_W, LINE_W = LINE_WORDS·DATA_W
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  invalidate all lines
- cpu_addr_valid  in  1  fetch request
- cpu_addr  in  ADDR_W  byte address of fetch
- cpu_data_ready  out  1  hit this cycle; cpu_data_o valid
- cpu_data_o  out  DATA_W  fetched word
- mem_addr_valid  out  1  refill request, registered
- mem_addr  out  ADDR_W  line-aligned refill address, registered
- mem_data_ready  in  1  mem_data_i valid this cycle
- mem_data_i  in  LINE_W  refill line; word k at bits [k·DATA_W +: DATA_W]

## Operation
- Address split: tag = cpu_addr[ADDR_W-1 : IDX_W+OFF_W], index = next IDX_W bits, word = cpu_addr[OFF_W-1 : log2(DATA_W/8)].
- Storage: per way per set: LINE_WORDS data words, TAG_W tag, valid bit. One LRU bit per set when WAYS=2 (value = way to evict next). Data and tags are not reset.
- FSM states: IDLE, REFILL.
- IDLE:
  - hit = cpu_addr_valid & ~flush & some way has valid=1 and a matching tag. cpu_data_ready = hit, combinational. cpu_data_o = selected word of the hitting way, else 0.
  - On hit with WAYS=2: lru[index] is set to the other way.
  - On cpu_addr_valid & ~flush & ~hit: latch tag/index. Set mem_addr = {tag, index, OFF_W zeros} and mem_addr_valid = 1. Go to REFILL.
  - On flush: all valid bits clear at the edge. No refill starts.
- REFILL:
  - cpu_data_ready = 0 regardless of address. The cache blocks.
  - mem_addr_valid and mem_addr hold stable until mem_data_ready is sampled high.
  - On mem_data_ready: the victim way is the lowest-numbered invalid way, else lru[index]. Write the full line, tag and valid=1 for the latched index. Set lru[index] to the other way. Clear mem_addr_valid. Go to IDLE.
  - cpu_addr_valid dropping or cpu_addr changing during REFILL does not abort; the latched line still fills.
  - A flush seen at any cycle in REFILL (including the fill cycle) is recorded as pending. At the fill, all valid bits clear and the filled line is written with valid=0. Pending clears.
- mem_data_ready outside REFILL is ignored.
- Reset mid-refill: returns to IDLE immediately and clears all valids. The late mem_data_ready is ignored.

## Timing
- Reset values: state IDLE, all valid 0, all lru 0, flush-pending 0, mem_addr_valid 0, mem_addr 0, cpu_data_ready 0, cpu_data_o 0.
- Hit latency: 0 cycles (same-cycle combinational).
- Miss seen in cycle N: mem_addr_valid = 1 from cycle N+1.
- mem_data_ready sampled in cycle M ≥ N+1: mem_addr_valid = 0 and state IDLE in M+1. cpu_data_ready = 1 in M+1 if the same address is still presented.
- Minimum miss penalty: 2 cycles (N → N+2).
- The CPU holds cpu_addr stable while cpu_data_ready = 0. Otherwise a new lookup happens on return to IDLE.

## Test plan
- Reset, then cpu_addr_valid with cpu_addr=0x0000_1044 -> cpu_data_ready=0; next cycle mem_addr_valid=1, mem_addr=0x0000_1040.
- Continue that miss: mem_data_ready with word k = 0xA000_0000+k two cycles later -> mem_addr_valid=0 next cycle; same cycle cpu_data_ready=1, cpu_data_o=0xA000_0001. Then 0x1040 -> 0xA000_0000 and 0x107C -> 0xA000_000F with zero latency.
- WAYS=2, SETS=64, LINE 64B: fill 0x0000_1000, 0x0000_2000 (same set), re-read 0x1000, then miss 0x0000_3000 -> 0x2000 line is evicted (re-miss); 0x1000 and 0x3000 hit.
- WAYS=1: fill 0x1000 then 0x2000 -> 0x1000 re-misses; mem_addr=0x0000_1000.
- flush pulse in IDLE -> all previously hitting addresses miss. A flush during REFILL -> the fill completes, mem_addr_valid drops, and the same address misses again.
- rst_n low while in REFILL -> mem_addr_valid=0 immediately; a mem_data_ready after release writes nothing; the address still misses.
